// File: rtl/bcd_to_binary.sv
// Sequential 3-digit BCD (0..255) to 8-bit binary converter, reverse double-dabble over 8 iterations.
// Optional input legality check enabled by defining BCD2BIN_CHECK_EN.
module bcd_to_binary (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] HUNDREDS,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  output logic       out_valid,
  output logic [7:0] B,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [17:0] work, work_sh;
  logic [2:0]  cnt;
  logic [7:0]  b_res;
  logic        last;

  assign last      = (cnt == 3'd7);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One iteration: shift right, then pull 3 out of any BCD digit that reached 8.
  always_comb begin
    work_sh = {1'b0, work[17:1]};
    if (work_sh[15:12] >= 4'd8) work_sh[15:12] = work_sh[15:12] - 4'd3;
    if (work_sh[11:8]  >= 4'd8) work_sh[11:8]  = work_sh[11:8]  - 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (last)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
      B    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work <= {HUNDREDS, TENS, ONES, 8'h00};
          cnt  <= '0;
        end
        SHIFT: begin
          work <= work_sh;
          cnt  <= cnt + 3'd1;
          if (last) B <= b_res;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic [7:0] tens_ones;
  logic       err_ld, err_q;

  // Only meaningful for legal digits; any overflow here coincides with an illegal digit.
  assign tens_ones = {4'b0, TENS} * 8'd10 + {4'b0, ONES};
  assign err_ld    = (TENS > 4'd9) || (ONES > 4'd9) || (HUNDREDS == 2'd3) ||
                     ((HUNDREDS == 2'd2) && (tens_ones > 8'd55));
  assign b_res     = err_q ? 8'h00 : work_sh[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) err_q <= err_ld;
      if (state == SHIFT && last)    err   <= err_q;
    end
  end
`else
  assign b_res = work_sh[7:0];
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed cases plus randomized digits vs an arithmetic model.
module tb_bcd_to_binary;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] HUNDREDS = '0;
  logic [3:0] TENS = '0;
  logic [3:0] ONES = '0;
  logic       out_valid;
  logic [7:0] B;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_to_binary dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .HUNDREDS(HUNDREDS), .TENS(TENS), .ONES(ONES),
    .out_valid(out_valid), .B(B), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the digits, wrapped to 8 bits; error rule only with checking built.
  task automatic model(input int h, input int t, input int o,
                       output logic [7:0] b, output logic e);
`ifdef BCD2BIN_CHECK_EN
    e = (t > 9) || (o > 9) || (h == 3) || (h == 2 && 10 * t + o > 55);
`else
    e = 1'b0;
`endif
    b = e ? 8'h00 : 8'((100 * h + 10 * t + o) % 256);
  endtask

  // Full transaction with latency, hold and handshake checks.
  task automatic convert(input int h, input int t, input int o, input string tag);
    logic [7:0] eb, prev_b;
    logic       ee;
    int         cyc;
    model(h, t, o, eb, ee);
    @(negedge clk);
    prev_b   = B;
    in_valid = 1'b1;
    HUNDREDS = 2'(h); TENS = 4'(t); ONES = 4'(o);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " ready_low"}, 16'(in_ready), 16'h0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (cyc == 4) chk({tag, " b_hold"}, 16'(B), 16'(prev_b));
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 16'(cyc), 16'd8);
    chk({tag, " B"}, 16'(B), 16'(eb));
    chk({tag, " err"}, 16'(err), 16'(ee));
    @(posedge clk); #1;
    chk({tag, " vld_fall"}, 16'(out_valid), 16'h0);
    chk({tag, " ready_rise"}, 16'(in_ready), 16'h1);
    chk({tag, " B_keep"}, 16'(B), 16'(eb));
  endtask

  initial begin
    int pulses, n;
    int h, t, o;

    // reset state
    #12;
    chk("rst in_ready", 16'(in_ready), 16'h1);
    chk("rst out_valid", 16'(out_valid), 16'h0);
    chk("rst B", 16'(B), 16'h0);
    chk("rst err", 16'(err), 16'h0);
    @(negedge clk); rst_n = 1'b1;

    convert(2, 5, 5, "255");
    convert(0, 0, 0, "000");
    convert(1, 2, 8, "128");
`ifdef BCD2BIN_CHECK_EN
    convert(2, 9, 9, "299chk");
    convert(0, 0, 10, "00Achk");
    convert(3, 0, 0, "300chk");
    convert(2, 5, 6, "256chk");
`else
    convert(2, 9, 9, "299raw");
`endif

    // full sweep of legal values from binary-to-BCD conversion
    for (int v = 0; v < 256; v++) convert(v / 100, (v / 10) % 10, v % 10, "sweep");

    // random legal digits, wrapping values included
    for (int i = 0; i < 30; i++)
      convert($urandom_range(2, 0), $urandom_range(9, 0), $urandom_range(9, 0), "rand");
`ifdef BCD2BIN_CHECK_EN
    for (int i = 0; i < 10; i++)
      convert($urandom_range(3, 0), $urandom_range(15, 0), $urandom_range(15, 0), "rand_chk");
`endif

    // in_valid held during conversion is ignored until IDLE
    @(negedge clk);
    in_valid = 1'b1; HUNDREDS = 2'd1; TENS = 4'd0; ONES = 4'd0;
    @(posedge clk); #1;
    ONES = 4'd7; HUNDREDS = 2'd0;
    pulses = 0; n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("busy first_lat", 16'(n), 16'd8);
    chk("busy first_B", 16'(B), 16'h64);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (!in_ready) in_valid = 1'b0;
      if (out_valid) pulses++;
    end while (!out_valid && n < 20);
    chk("busy second_gap", 16'(n), 16'd10);
    chk("busy pulses", 16'(pulses), 16'd1);
    chk("busy second_B", 16'(B), 16'h07);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset mid-conversion
    @(negedge clk);
    in_valid = 1'b1; HUNDREDS = 2'd2; TENS = 4'd0; ONES = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst B", 16'(B), 16'h0);
    chk("mid_rst err", 16'(err), 16'h0);
    chk("mid_rst in_ready", 16'(in_ready), 16'h1);
    chk("mid_rst out_valid", 16'(out_valid), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) pulses++; end
    chk("mid_rst no_pulse", 16'(pulses), 16'h0);
    convert(0, 4, 2, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
